// File: rtl/run_ctrl_pkg.sv
// Shared state encoding, end-cause codes and width helper for the run controller.
package run_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } run_state_e;

   typedef enum logic [1:0] {
      STAT_NONE    = 2'd0,
      STAT_HALT    = 2'd1,
      STAT_LOOP    = 2'd2,
      STAT_TIMEOUT = 2'd3
   } run_status_e;

   // Bits needed to hold values 0..n-1, never less than one.
   function automatic int unsigned cnt_bits(input int unsigned n);
      return (n > 32'd1) ? $clog2(n) : 32'd1;
   endfunction

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] q
);

   logic [CNT_W-1:0] r_q;

   // Count register: reset/clear to zero, increment until all-ones.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_q <= '0;
      end else if (inc && (r_q != {CNT_W{1'b1}})) begin
         r_q <= r_q + CNT_W'(1);
      end else begin
         r_q <= r_q;
      end
   end

   assign q = r_q;

endmodule

// File: rtl/run_ctrl.sv
// Run controller: launches the CPU after a start delay, counts cycles and events,
// and stops on halt, PC self-loop or cycle budget exhaustion.
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int PC_W        = 32,
   parameter int NUM_EV      = 4,
   parameter int START_DELAY = 1,
   parameter int MAX_CYCLES  = 300,
   parameter int STALL_LIMIT = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    go,
   input  logic [PC_W-1:0]         pc_i,
   input  logic                    halt_i,
   input  logic [NUM_EV-1:0]       ev_i,
   output logic                    cpu_start,
   output logic                    done,
   output logic [1:0]              status,
   output logic [CNT_W-1:0]        cycle_cnt,
   output logic [NUM_EV*CNT_W-1:0] ev_cnt
);

   localparam int DLY_W   = cnt_bits(START_DELAY);
   localparam int STALL_W = cnt_bits(STALL_LIMIT + 1);

   run_state_e        r_state, w_state_nxt;
   run_status_e       r_status, w_status_nxt;
   logic [DLY_W-1:0]  r_dly, w_dly_nxt;
   logic [STALL_W-1:0] r_stall, w_stall_nxt;
   logic [PC_W-1:0]   r_prev_pc;
   logic              r_prev_run;
   logic              w_run;
   logic              w_clr;
   logic              w_timeout;
   logic [CNT_W+31:0] w_cyc_ext;

   assign w_run     = (r_state == ST_RUN);
   // Widened compare so a counter too narrow to reach the budget simply never times out.
   assign w_cyc_ext = {32'd0, cycle_cnt};
   assign w_timeout = (w_cyc_ext == (CNT_W + 32)'(MAX_CYCLES - 1));

   // Next-state, end-cause and stall tracking.
   always_comb begin
      w_state_nxt  = r_state;
      w_status_nxt = r_status;
      w_dly_nxt    = r_dly;
      w_stall_nxt  = r_stall;
      w_clr        = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (go) begin
               w_clr        = 1'b1;
               w_status_nxt = STAT_NONE;
               w_stall_nxt  = '0;
               w_dly_nxt    = '0;
               w_state_nxt  = (START_DELAY == 0) ? ST_RUN : ST_DELAY;
            end else begin
               w_state_nxt = r_state;
            end
         end
         ST_DELAY: begin
            if (r_dly == DLY_W'(START_DELAY - 1)) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_dly_nxt = r_dly + DLY_W'(1);
            end
         end
         ST_RUN: begin
            // The first RUN cycle has no valid previous PC to compare against.
            if (r_prev_run && (pc_i == r_prev_pc)) begin
               w_stall_nxt = r_stall + STALL_W'(1);
            end else begin
               w_stall_nxt = '0;
            end
            if (halt_i) begin
               w_status_nxt = STAT_HALT;
               w_state_nxt  = ST_DONE;
            end else if (w_stall_nxt == STALL_W'(STALL_LIMIT)) begin
               w_status_nxt = STAT_LOOP;
               w_state_nxt  = ST_DONE;
            end else if (w_timeout) begin
               w_status_nxt = STAT_TIMEOUT;
               w_state_nxt  = ST_DONE;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_status   <= STAT_NONE;
         r_dly      <= '0;
         r_stall    <= '0;
         r_prev_pc  <= '0;
         r_prev_run <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_status   <= w_status_nxt;
         r_dly      <= w_dly_nxt;
         r_stall    <= w_stall_nxt;
         r_prev_pc  <= pc_i;
         r_prev_run <= w_run;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
      .clk (clk),
      .rst (rst),
      .clr (w_clr),
      .inc (w_run),
      .q   (cycle_cnt)
   );

   for (genvar g = 0; g < NUM_EV; g++) begin : g_ev
      sat_counter #(.CNT_W(CNT_W)) u_ev_cnt (
         .clk (clk),
         .rst (rst),
         .clr (w_clr),
         .inc (w_run && ev_i[g]),
         .q   (ev_cnt[g*CNT_W +: CNT_W])
      );
   end

   assign cpu_start = w_run;
   assign done      = (r_state == ST_DONE);
   assign status    = r_status;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed self-checking bench for run_ctrl: default, narrow-counter and zero-delay instances.
module tb_run_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        go0, go1, go2;
   logic [31:0] pc;
   logic        halt;
   logic [3:0]  ev;
   logic        hold_pc;

   logic         cs0, dn0, cs1, dn1, cs2, dn2;
   logic [1:0]   st0, st1, st2;
   logic [31:0]  cc0, cc2;
   logic [3:0]   cc1;
   logic [127:0] ec0, ec2;
   logic [15:0]  ec1;

   int n_err = 0;
   int n_checks = 0;

   always #5 clk = ~clk;

   run_ctrl u0 (
      .clk(clk), .rst(rst), .go(go0), .pc_i(pc), .halt_i(halt), .ev_i(ev),
      .cpu_start(cs0), .done(dn0), .status(st0), .cycle_cnt(cc0), .ev_cnt(ec0)
   );

   run_ctrl #(.CNT_W(4), .MAX_CYCLES(20)) u1 (
      .clk(clk), .rst(rst), .go(go1), .pc_i(pc), .halt_i(halt), .ev_i(ev),
      .cpu_start(cs1), .done(dn1), .status(st1), .cycle_cnt(cc1), .ev_cnt(ec1)
   );

   run_ctrl #(.START_DELAY(0)) u2 (
      .clk(clk), .rst(rst), .go(go2), .pc_i(pc), .halt_i(halt), .ev_i(ev),
      .cpu_start(cs2), .done(dn2), .status(st2), .cycle_cnt(cc2), .ev_cnt(ec2)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample point is 1ns after the rising edge; PC advances unless held.
   task automatic step();
      @(posedge clk);
      #1;
      if (!hold_pc) pc = pc + 32'd4;
   endtask

   initial begin
      rst = 1'b1; go0 = 1'b0; go1 = 1'b0; go2 = 1'b0;
      pc = 32'h0000_1000; halt = 1'b0; ev = 4'd0; hold_pc = 1'b0;
      step(); step();
      chk("rst_cpu_start", 64'(cs0), 64'd0);
      chk("rst_done", 64'(dn0), 64'd0);
      chk("rst_status", 64'(st0), 64'd0);
      chk("rst_cycle_cnt", 64'(cc0), 64'd0);
      chk("rst_ev_any", 64'(ec0 != 128'd0), 64'd0);
      rst = 1'b0;
      step();

      // Timeout run: DELAY one cycle, RUN for exactly 300 cycles.
      go0 = 1'b1; step(); go0 = 1'b0;
      chk("A_delay_cpu_start", 64'(cs0), 64'd0);
      step();
      chk("A_run_cpu_start", 64'(cs0), 64'd1);
      chk("A_run_cnt0", 64'(cc0), 64'd0);
      repeat (299) step();
      chk("A_cnt299", 64'(cc0), 64'd299);
      chk("A_not_done", 64'(dn0), 64'd0);
      step();
      chk("A_done", 64'(dn0), 64'd1);
      chk("A_status", 64'(st0), 64'd3);
      chk("A_cnt300", 64'(cc0), 64'd300);
      chk("A_cpu_start_off", 64'(cs0), 64'd0);
      ev = 4'hF; step(); step();
      chk("A_frozen_cnt", 64'(cc0), 64'd300);
      chk("A_no_ev_in_done", 64'(ec0 != 128'd0), 64'd0);

      // Restart from DONE, halt on the 10th RUN cycle, channel 0 strobing.
      ev = 4'b0001;
      go0 = 1'b1; step(); go0 = 1'b0;
      chk("B_clr_cnt", 64'(cc0), 64'd0);
      chk("B_clr_status", 64'(st0), 64'd0);
      chk("B_clr_done", 64'(dn0), 64'd0);
      step();
      chk("B_no_ev_in_delay", 64'(ec0 != 128'd0), 64'd0);
      repeat (9) step();
      halt = 1'b1; step(); halt = 1'b0;
      chk("B_status", 64'(st0), 64'd1);
      chk("B_done", 64'(dn0), 64'd1);
      chk("B_cnt", 64'(cc0), 64'd10);
      chk("B_ev0", 64'(ec0[31:0]), 64'd10);
      chk("B_ev_hi", 64'(ec0[127:32] != 96'd0), 64'd0);
      ev = 4'd0;

      // Self-loop: PC frozen at 0x40 from RUN cycle 5, eight equal compares.
      go0 = 1'b1; step(); go0 = 1'b0;
      step();
      repeat (4) step();
      hold_pc = 1'b1; pc = 32'h40;
      repeat (8) step();
      chk("C_not_done", 64'(dn0), 64'd0);
      chk("C_cnt12", 64'(cc0), 64'd12);
      step();
      chk("C_done", 64'(dn0), 64'd1);
      chk("C_status", 64'(st0), 64'd2);
      chk("C_cnt13", 64'(cc0), 64'd13);
      hold_pc = 1'b0;

      // Halt coinciding with the last budget cycle: halt wins.
      go0 = 1'b1; step(); go0 = 1'b0;
      step();
      repeat (299) step();
      halt = 1'b1; step(); halt = 1'b0;
      chk("D_status", 64'(st0), 64'd1);
      chk("D_cnt", 64'(cc0), 64'd300);
      chk("D_done", 64'(dn0), 64'd1);

      // Reset mid-RUN dominates go/halt/ev, then a clean restart.
      ev = 4'hF;
      go0 = 1'b1; step(); go0 = 1'b0;
      step();
      repeat (49) step();
      chk("R_cnt49", 64'(cc0), 64'd49);
      chk("R_ev0_49", 64'(ec0[31:0]), 64'd49);
      rst = 1'b1; go0 = 1'b1; halt = 1'b1;
      step();
      chk("R_cpu_start", 64'(cs0), 64'd0);
      chk("R_done", 64'(dn0), 64'd0);
      chk("R_status", 64'(st0), 64'd0);
      chk("R_cnt", 64'(cc0), 64'd0);
      chk("R_ev_any", 64'(ec0 != 128'd0), 64'd0);
      rst = 1'b0; go0 = 1'b0; halt = 1'b0;
      step();
      chk("R_idle", 64'(cs0), 64'd0);
      go0 = 1'b1; step(); go0 = 1'b0;
      step();
      chk("R2_run", 64'(cs0), 64'd1);
      chk("R2_cnt0", 64'(cc0), 64'd0);
      step();
      chk("R2_cnt1", 64'(cc0), 64'd1);
      chk("R2_ev_all1", 64'(ec0 == {4{32'd1}}), 64'd1);
      rst = 1'b1; step(); rst = 1'b0;

      // Narrow counters saturate at 15 and never wrap.
      ev = 4'b0010;
      go1 = 1'b1; step(); go1 = 1'b0;
      step();
      repeat (15) step();
      chk("F_cnt15", 64'(cc1), 64'd15);
      chk("F_ev", 64'(ec1), 64'h00F0);
      repeat (10) step();
      chk("F_cnt_sat", 64'(cc1), 64'd15);
      chk("F_ev_sat", 64'(ec1), 64'h00F0);
      rst = 1'b1; step(); rst = 1'b0;
      ev = 4'd0;

      // Zero start delay: RUN the cycle after go; go ignored while running.
      go2 = 1'b1; step(); go2 = 1'b0;
      chk("E_run_now", 64'(cs2), 64'd1);
      chk("E_cnt0", 64'(cc2), 64'd0);
      step(); step();
      halt = 1'b1; step(); halt = 1'b0;
      chk("E_done", 64'(dn2), 64'd1);
      chk("E_status", 64'(st2), 64'd1);
      chk("E_cnt3", 64'(cc2), 64'd3);
      go2 = 1'b1; step();
      chk("E_restart_run", 64'(cs2), 64'd1);
      chk("E_restart_done", 64'(dn2), 64'd0);
      chk("E_restart_status", 64'(st2), 64'd0);
      chk("E_restart_cnt", 64'(cc2), 64'd0);
      step();
      chk("E_go_ignored_cnt", 64'(cc2), 64'd1);
      chk("E_go_ignored_run", 64'(cs2), 64'd1);
      go2 = 1'b0; step();
      chk("E_cnt2", 64'(cc2), 64'd2);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
- REQ-001 SHALL have parameter CNT_W, default 32, width of every counter.
- REQ-002 SHALL have parameter PC_W, default 32, width of the PC being monitored.
- REQ-003 SHALL have parameter NUM_EV, default 4, number of event counter channels (1..16).
- REQ-004 SHALL have parameter START_DELAY, default 1, cycles from go to cpu_start assertion (0 allowed).
- REQ-005 SHALL have parameter MAX_CYCLES, default 300, RUN cycle budget before timeout (>=1).
- REQ-006 SHALL have parameter STALL_LIMIT, default 8, consecutive equal-PC cycles that mean self-loop (>=1).
- REQ-007 SHALL have port clk  input  1  system clock, all state on rising edge.
- REQ-008 SHALL have port rst  input  1  synchronous reset, active-high.
- REQ-009 SHALL have port go  input  1  run request, sampled each cycle.
- REQ-010 SHALL have port pc_i  input  PC_W  CPU program counter.
- REQ-011 SHALL have port halt_i  input  1  CPU retired ecall/ebreak this cycle.
- REQ-012 SHALL have port ev_i  input  NUM_EV  per-channel event strobes.
- REQ-013 SHALL have port cpu_start  output  1  CPU run enable, high only in RUN.
- REQ-014 SHALL have port done  output  1  high only in DONE.
- REQ-015 SHALL have port status  output  2  end cause: 0 none, 1 halt, 2 self-loop, 3 timeout.
- REQ-016 SHALL have port cycle_cnt  output  CNT_W  RUN cycles completed.
- REQ-017 SHALL have port ev_cnt  output  NUM_EV*CNT_W  packed counters, channel i at bits [i*CNT_W +: CNT_W].

Function
- REQ-018 SHALL implement states IDLE, DELAY, RUN, DONE; all outputs registered or decoded from state only.
- REQ-019 IDLE: go=1 SHALL clear cycle_cnt, ev_cnt, status, stall counter, and enter DELAY (or RUN if START_DELAY=0).
- REQ-020 DELAY SHALL last exactly START_DELAY cycles, then enter RUN; cpu_start first high START_DELAY+1 cycles after go is sampled.
- REQ-021 RUN: each cycle SHALL increment cycle_cnt and each ev_cnt[i] with ev_i[i]=1, saturating at all-ones.
- REQ-022 RUN: halt_i=1 SHALL count that cycle, set status=1, and enter DONE next cycle.
- REQ-023 RUN: pc_i equal to previous-cycle pc_i SHALL increment stall count, else clear it; first RUN cycle never compares.
- REQ-024 Stall count reaching STALL_LIMIT SHALL set status=2 and enter DONE.
- REQ-025 cycle_cnt reaching MAX_CYCLES SHALL set status=3 and enter DONE; done cycle has cycle_cnt==MAX_CYCLES.
- REQ-026 Simultaneous end causes SHALL resolve by priority halt > self-loop > timeout.
- REQ-027 go SHALL be ignored in DELAY and RUN.
- REQ-028 DONE SHALL freeze counters and status; go=1 in DONE SHALL behave as REQ-019 (restart).
- REQ-029 Event strobes outside RUN SHALL NOT be counted.

Reset
- REQ-030 rst=1 SHALL, at next edge, force IDLE, cpu_start=0, done=0, status=0, cycle_cnt=0, ev_cnt=0, stall count=0.
- REQ-031 rst SHALL dominate go, halt_i and ev_i, including mid-RUN and in DONE.

Structure
- REQ-032 State encoding and status codes SHALL live in shared package run_ctrl_pkg.
- REQ-033 Per-channel saturating counter SHALL be sub-module sat_counter (CNT_W param, clr, inc), instantiated NUM_EV times plus once for cycle_cnt.

Verification
- REQ-034 Defaults, go pulse at cycle 2, PC increments by 4 forever -> cpu_start high from cycle 4, done with status=3, cycle_cnt=300.
- REQ-035 halt_i pulsed on 10th RUN cycle with ev_i=4'b0001 every RUN cycle -> status=1, cycle_cnt=10, ev_cnt[0]=10, others 0.
- REQ-036 PC held at 0x40 from RUN cycle 5 -> status=2 after 8 equal compares; halt_i and timeout same cycle -> status=1.
- REQ-037 CNT_W=4, MAX_CYCLES=20, ev_i[1]=1 every cycle -> ev_cnt[1] saturates at 15, cycle_cnt saturates at 15, never wraps.
- REQ-038 rst asserted on RUN cycle 50 -> all outputs zero next edge; later go restarts with counters from 0.
- REQ-039 START_DELAY=0, go in DONE -> RUN entered next cycle, counters cleared, go during RUN ignored.
